// File: rtl/mem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// load funct3 codes and the byte-lane merge helper.
package mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                 input logic [31:0] new_w,
                                                 input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request bus between the core controller (master) and the
// data memory (slave).
interface mem_responder_if;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wrbits;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_ready;
    logic        mem_err;

    modport master (
        output mem_read, mem_write, mem_wrbits, addr, funct3, wdata,
        input  rdata, mem_ready, mem_err
    );

    modport slave (
        input  mem_read, mem_write, mem_wrbits, addr, funct3, wdata,
        output rdata, mem_ready, mem_err
    );
endinterface

// File: rtl/mem_responder_load_align.sv
// Combinational load formatter: picks the addressed byte/half/word and
// extends it, flagging misaligned accesses and unsupported funct3 codes.
module mem_load_align
    import mem_responder_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o,
    output logic        misalign_o,
    output logic        illegal_o
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection, then extension chosen by funct3.
    always_comb begin
        data_o     = 32'h0000_0000;
        misalign_o = 1'b0;
        illegal_o  = 1'b0;
        case (off_i)
            2'd0:    byte_s = word_i[7:0];
            2'd1:    byte_s = word_i[15:8];
            2'd2:    byte_s = word_i[23:16];
            default: byte_s = word_i[31:24];
        endcase
        half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  data_o = {24'h00_0000, byte_s};
            F3_LH: begin
                data_o     = {{16{half_s[15]}}, half_s};
                misalign_o = off_i[0];
            end
            F3_LHU: begin
                data_o     = {16'h0000, half_s};
                misalign_o = off_i[0];
            end
            F3_LW: begin
                data_o     = word_i;
                misalign_o = (off_i != 2'd0);
            end
            default: illegal_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/mem_responder.sv
// Word-organised data RAM answering controller load/store requests with
// programmable wait states, a one-cycle ready pulse and error reporting.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int AW       = 10,
    parameter int WAIT_CYC = 1
) (
    input  logic           clock,
    input  logic           reset,
    mem_responder_if.slave bus
);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYC - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rd_q, wr_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [2:0]    f3_q;
    logic [3:0]    be_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d, err_q, err_d;
    logic          req_s, accept_s, err_s, we_s;
    logic          misalign_s, illegal_s;
    logic [31:0]   word_s, load_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   ram_q [0:(1<<AW)-1];
    logic          addr_unused_s;

    assign req_s         = bus.mem_read | bus.mem_write;
    assign accept_s      = (state_q == ST_IDLE) && req_s;
    assign idx_s         = addr_q[AW+1:2];
    assign word_s        = ram_q[idx_s];
    assign addr_unused_s = ^bus.addr[31:AW+2];

    mem_load_align u_align (
        .word_i     (word_s),
        .off_i      (addr_q[1:0]),
        .funct3_i   (f3_q),
        .data_o     (load_s),
        .misalign_o (misalign_s),
        .illegal_o  (illegal_s)
    );

    // State register and wait counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; HOLD waits for the request to drop so a held request runs once.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    cnt_d   = 4'd0;
                    state_d = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d   = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_HOLD;
            ST_HOLD: begin
                if (!req_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Request capture at accept; the copy is used for the rest of the access.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'h0000_0000;
            f3_q    <= 3'b000;
            be_q    <= 4'b0000;
        end else if (accept_s) begin
            rd_q    <= bus.mem_read;
            wr_q    <= bus.mem_write;
            addr_q  <= bus.addr[AW+1:0];
            wdata_q <= bus.wdata;
            f3_q    <= bus.funct3;
            be_q    <= bus.mem_wrbits;
        end
    end

    // Output logic: access happens in RESP, rejected requests touch nothing.
    always_comb begin
        err_s   = (rd_q & wr_q) | (rd_q & (misalign_s | illegal_s));
        ready_d = (state_q == ST_RESP);
        err_d   = ready_d & err_s;
        we_s    = ready_d & wr_q & ~err_s;
        if (ready_d && rd_q && !err_s) begin
            rdata_d = load_s;
        end else begin
            rdata_d = rdata_q;
        end
    end

    // Registered outputs: ready/err pulse together with the updated rdata.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rdata_q <= 32'h0000_0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // RAM write port with per-lane enables; contents survive reset.
    always_ff @(posedge clock) begin
        if (we_s) begin
            ram_q[idx_s] <= merge_lanes(word_s, wdata_q, be_q);
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_err   = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Table-driven scoreboard bench for mem_responder (WAIT_CYC=1 and WAIT_CYC=3 instances).
module tb_mem_responder;
    import mem_responder_pkg::*;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if bus1();
    mem_responder_if bus2();

    mem_responder #(.AW(10), .WAIT_CYC(1)) dut1 (.clock(clk), .reset(rst_n), .bus(bus1));
    mem_responder #(.AW(10), .WAIT_CYC(3)) dut2 (.clock(clk), .reset(rst_n), .bus(bus2));

    exp_t q1[$];
    exp_t q2[$];
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   pulses1 = 0;
    int   pulses2 = 0;
    vec_t vecs[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic [3:0] be,
                                input logic [31:0] a, input logic [2:0] f3,
                                input logic [31:0] wd, input logic [31:0] er, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.be = be; v.addr = a; v.f3 = f3;
        v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus1.mem_ready : bus2.mem_ready;
    endfunction

    task automatic drive(input int sel, input logic rd, input logic wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [2:0] f3, input logic [31:0] wd);
        if (sel == 0) begin
            bus1.mem_read = rd; bus1.mem_write = wr; bus1.mem_wrbits = be;
            bus1.addr = a; bus1.funct3 = f3; bus1.wdata = wd;
        end else begin
            bus2.mem_read = rd; bus2.mem_write = wr; bus2.mem_wrbits = be;
            bus2.addr = a; bus2.funct3 = f3; bus2.wdata = wd;
        end
    endtask

    // Scoreboard: every ready pulse pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus1.mem_ready) begin
            pulses1++;
            if (q1.size() == 0) begin
                check("dut1_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                check("dut1_rdata", bus1.rdata, e.rdata);
                check("dut1_err", {31'd0, bus1.mem_err}, {31'd0, e.err});
            end
        end else if (bus1.mem_err) begin
            check("dut1_err_without_ready", 32'd1, 32'd0);
        end
        if (bus2.mem_ready) begin
            pulses2++;
            if (q2.size() == 0) begin
                check("dut2_unexpected_ready", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                check("dut2_rdata", bus2.rdata, e.rdata);
                check("dut2_err", {31'd0, bus2.mem_err}, {31'd0, e.err});
            end
        end else if (bus2.mem_err) begin
            check("dut2_err_without_ready", 32'd1, 32'd0);
        end
    end

    task automatic run(input int sel, input vec_t v, input int exp_lat, input string name);
        exp_t e;
        int   lat;
        logic seen;
        e.rdata = v.exp_rdata;
        e.err   = v.exp_err;
        if (sel == 0) q1.push_back(e); else q2.push_back(e);
        @(negedge clk);
        drive(sel, v.rd, v.wr, v.be, v.addr, v.f3, v.wdata);
        seen = 1'b0;
        lat  = 0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (rdy(sel)) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        else       check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        drive(sel, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0);
        @(negedge clk);
        check({name, "_pulse_width"}, {31'd0, rdy(sel)}, 32'd0);
    endtask

    initial begin
        int   p;
        exp_t e;

        vecs[0]  = mk(1'b0, 1'b1, 4'hF, 32'h10,   F3_LW,  32'hDEADBEEF, 32'h0000_0000, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 4'h0, 32'h10,   F3_LW,  32'h0,        32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 4'hF, 32'h20,   F3_LW,  32'h11223344, 32'hDEADBEEF, 1'b0);
        vecs[3]  = mk(1'b0, 1'b1, 4'h4, 32'h20,   F3_LW,  32'h00AA0000, 32'hDEADBEEF, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, 4'h0, 32'h20,   F3_LW,  32'h0,        32'h11AA3344, 1'b0);
        vecs[5]  = mk(1'b0, 1'b1, 4'hF, 32'h30,   F3_LW,  32'h80FF7F01, 32'h11AA3344, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 4'h0, 32'h33,   F3_LB,  32'h0,        32'hFFFFFF80, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 4'h0, 32'h33,   F3_LBU, 32'h0,        32'h00000080, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 4'h0, 32'h32,   F3_LH,  32'h0,        32'hFFFF80FF, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 4'h0, 32'h30,   F3_LHU, 32'h0,        32'h00007F01, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 4'h0, 32'h31,   F3_LW,  32'h0,        32'h00007F01, 1'b1);
        vecs[11] = mk(1'b1, 1'b1, 4'hF, 32'h30,   F3_LW,  32'h0,        32'h00007F01, 1'b1);
        vecs[12] = mk(1'b1, 1'b0, 4'h0, 32'h30,   F3_LW,  32'h0,        32'h80FF7F01, 1'b0);
        vecs[13] = mk(1'b0, 1'b1, 4'h0, 32'h30,   F3_LW,  32'hFFFFFFFF, 32'h80FF7F01, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 4'h0, 32'h1030, F3_LW,  32'h0,        32'h80FF7F01, 1'b0);
        vecs[15] = mk(1'b1, 1'b0, 4'h0, 32'h30,   3'b011, 32'h0,        32'h80FF7F01, 1'b1);
        vecs[16] = mk(1'b1, 1'b0, 4'h0, 32'h31,   F3_LH,  32'h0,        32'h80FF7F01, 1'b1);
        vecs[17] = mk(1'b1, 1'b0, 4'h0, 32'h30,   F3_LB,  32'h0,        32'h00000001, 1'b0);
        vecs[18] = mk(1'b1, 1'b0, 4'h0, 32'h31,   F3_LB,  32'h0,        32'h0000007F, 1'b0);
        vecs[19] = mk(1'b1, 1'b0, 4'h0, 32'h30,   F3_LH,  32'h0,        32'h00007F01, 1'b0);

        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0);
        repeat (3) @(negedge clk);
        check("reset_rdata1", bus1.rdata, 32'h0);
        check("reset_ready1", {31'd0, bus1.mem_ready}, 32'd0);
        check("reset_err1",   {31'd0, bus1.mem_err},   32'd0);
        check("reset_rdata2", bus2.rdata, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            run(0, vecs[i], 3, $sformatf("vec%0d", i));
        end

        // Held load: one pulse only, however long the request stays high.
        e.rdata = 32'hDEADBEEF;
        e.err   = 1'b0;
        q1.push_back(e);
        p = pulses1;
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 4'h0, 32'h10, F3_LW, 32'h0);
        repeat (9) @(negedge clk);
        check("held_pulse_count", 32'(pulses1 - p), 32'd1);
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0);
        @(negedge clk);
        run(0, mk(1'b1, 1'b0, 4'h0, 32'h20, F3_LW, 32'h0, 32'h11AA3344, 1'b0), 3, "after_drop");

        // Reset during WAIT on the WAIT_CYC=3 instance abandons the store.
        run(1, mk(1'b0, 1'b1, 4'hF, 32'h40, F3_LW, 32'hCAFEF00D, 32'h0, 1'b0), 5, "d2_sw_init");
        p = pulses2;
        @(negedge clk);
        drive(1, 1'b0, 1'b1, 4'hF, 32'h40, F3_LW, 32'h12345678);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 3'b000, 32'h0);
        check("d2_rdata_in_reset", bus2.rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("d2_no_ready_after_reset", 32'(pulses2 - p), 32'd0);
        run(1, mk(1'b1, 1'b0, 4'h0, 32'h40, F3_LW, 32'h0, 32'hCAFEF00D, 1'b0), 5, "d2_lw_after_rst");

        check("q1_drained", 32'(q1.size()), 32'd0);
        check("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
